// File: rtl/timer_apb_regs.sv
// APB register file (TDR/TCR/TSR) feeding the 8-bit timer counter core.
// Define TIMER_APB_IRQ_EN to add TIER at 0x03 and the registered irq output.

module timer_apb_regs #(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              ovf_set,
    input  logic              udf_set,
    output logic [7:0]        tdr_o,
    output logic              load_o,
    output logic              dw_o,
    output logic              en_o,
    output logic [1:0]        cks_o
`ifdef TIMER_APB_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam logic [ADDR_W-1:0] A_TDR = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TCR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TSR = ADDR_W'(2);
`ifdef TIMER_APB_IRQ_EN
    localparam logic [ADDR_W-1:0] A_TIER = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_MAX  = A_TIER;
`else
    localparam logic [ADDR_W-1:0] A_MAX  = A_TSR;
`endif
    localparam logic [7:0] TCR_MASK = 8'b1011_0011;
    localparam logic [2:0] WS       = 3'(WAIT_STATES);

    // WAIT covers the pready=0 access cycles, DONE is the single pready=1 cycle.
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  tdr_q, tdr_d;
    logic [7:0]  tcr_q, tcr_d;
    logic [1:0]  tsr_q, tsr_d;
    logic [7:0]  prdata_q, prdata_d;
    logic        err_q, err_d;
    logic        addr_ok, wr_en;
    logic [7:0]  rd_mux;
`ifdef TIMER_APB_IRQ_EN
    logic [1:0]  tier_q, tier_d;
    logic        irq_q;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // penable without a preceding setup cycle is ignored here
                if (psel && !penable) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pready  = (state_q == ST_DONE);
        pslverr = (state_q == ST_DONE) && err_q;
        wr_en   = (state_q == ST_DONE) && psel && penable && pwrite && addr_ok;
    end

    assign addr_ok = (paddr <= A_MAX);

    always_comb begin
        rd_mux = 8'h00;
        if (paddr == A_TDR) rd_mux = tdr_q;
        if (paddr == A_TCR) rd_mux = tcr_q;
        if (paddr == A_TSR) rd_mux = {6'b0, tsr_q};
`ifdef TIMER_APB_IRQ_EN
        if (paddr == A_TIER) rd_mux = {6'b0, tier_q};
`endif
    end

    // Read data and error are captured on the edge that enters the pready cycle.
    always_comb begin
        prdata_d = prdata_q;
        err_d    = err_q;
        if (state_d == ST_DONE) begin
            prdata_d = rd_mux;
            err_d    = !addr_ok;
        end
    end

    always_comb begin
        tdr_d = tdr_q;
        tcr_d = tcr_q;
        tsr_d = tsr_q;
        if (wr_en && paddr == A_TDR) tdr_d = pwdata;
        if (wr_en && paddr == A_TCR) tcr_d = pwdata & TCR_MASK;
        if (wr_en && paddr == A_TSR) tsr_d = tsr_q & pwdata[1:0];
        // hardware set wins over a same-cycle software clear
        tsr_d = tsr_d | {udf_set, ovf_set};
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tdr_q    <= '0;
            tcr_q    <= '0;
            tsr_q    <= '0;
            prdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            tdr_q    <= tdr_d;
            tcr_q    <= tcr_d;
            tsr_q    <= tsr_d;
            prdata_q <= prdata_d;
            err_q    <= err_d;
        end
    end

`ifdef TIMER_APB_IRQ_EN
    always_comb begin
        tier_d = tier_q;
        if (wr_en && paddr == A_TIER) tier_d = pwdata[1:0];
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tier_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            tier_q <= tier_d;
            irq_q  <= |(tsr_q & tier_q);
        end
    end

    assign irq = irq_q;
`endif

    assign prdata = prdata_q;
    assign tdr_o  = tdr_q;
    assign load_o = tcr_q[7];
    assign dw_o   = tcr_q[5];
    assign en_o   = tcr_q[4];
    assign cks_o  = tcr_q[1:0];

endmodule

// File: tb/tb_timer_apb_regs.sv
// Scoreboard bench: two instances (0 and 3 wait states) share one APB master
// and are compared against a register-level reference model.

module tb_timer_apb_regs;

    localparam int WS_A = 0;
    localparam int WS_B = 3;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pwdata = '0;
    logic       ovf_a = 1'b0, udf_a = 1'b0, ovf_b = 1'b0, udf_b = 1'b0;
    logic [7:0] prdata_a, prdata_b, tdr_a, tdr_b;
    logic       pready_a, pready_b, pslverr_a, pslverr_b;
    logic       load_a, load_b, dw_a, dw_b, en_a, en_b;
    logic [1:0] cks_a, cks_b;

    always #5 pclk = ~pclk;

    timer_apb_regs #(.WAIT_STATES(WS_A), .ADDR_W(8)) u_dut_a (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
        .pslverr(pslverr_a), .ovf_set(ovf_a), .udf_set(udf_a), .tdr_o(tdr_a),
        .load_o(load_a), .dw_o(dw_a), .en_o(en_a), .cks_o(cks_a));

    timer_apb_regs #(.WAIT_STATES(WS_B), .ADDR_W(8)) u_dut_b (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
        .pslverr(pslverr_b), .ovf_set(ovf_b), .udf_set(udf_b), .tdr_o(tdr_b),
        .load_o(load_b), .dw_o(dw_b), .en_o(en_b), .cks_o(cks_b));

    typedef struct {
        bit       wr;
        bit [7:0] addr;
        bit [7:0] rd;
        bit       err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // reference register state, index 0 = instance A, 1 = instance B
    bit [7:0] m_tdr[2];
    bit [7:0] m_tcr[2];
    bit [1:0] m_tsr[2];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tdr[k] = 8'h00;
            m_tcr[k] = 8'h00;
            m_tsr[k] = 2'b00;
        end
    endfunction

    // One completed transfer: read sees the old value, then write, then hardware set.
    function automatic exp_t model_xfer(input int k, input bit wr, input bit [7:0] a,
                                        input bit [7:0] d, input bit hw_ovf);
        exp_t e;
        e.wr   = wr;
        e.addr = a;
        e.err  = (a > 8'd2);
        case (a)
            8'd0:    e.rd = m_tdr[k];
            8'd1:    e.rd = m_tcr[k];
            8'd2:    e.rd = {6'b0, m_tsr[k]};
            default: e.rd = 8'h00;
        endcase
        if (wr && !e.err) begin
            case (a)
                8'd0: m_tdr[k] = d;
                8'd1: m_tcr[k] = {d[7], 1'b0, d[5], d[4], 2'b00, d[1], d[0]};
                8'd2: for (int b = 0; b < 2; b++) if (!d[b]) m_tsr[k][b] = 1'b0;
                default: ;
            endcase
        end
        if (hw_ovf) m_tsr[k][0] = 1'b1;
        return e;
    endfunction

    // Monitor: pops an expectation whenever an instance completes a transfer.
    always @(negedge pclk) begin
        exp_t e;
        if (preset === 1'b0) begin
            if (pready_a) begin
                if (qa.size() == 0) chk("a_unexpected_pready", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_pslverr", pslverr_a, e.err);
                    if (!e.wr) chk($sformatf("a_prdata@%0h", e.addr), prdata_a, e.rd);
                end
            end
            if (pready_b) begin
                if (qb.size() == 0) chk("b_unexpected_pready", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_pslverr", pslverr_b, e.err);
                    if (!e.wr) chk($sformatf("b_prdata@%0h", e.addr), prdata_b, e.rd);
                end
            end
            if (pslverr_a && !pready_a) chk("a_pslverr_outside_pready", 1, 0);
            if (pslverr_b && !pready_b) chk("b_pslverr_outside_pready", 1, 0);
        end
    end

    task automatic chk_ctrl();
        chk("a_tdr_o", tdr_a, m_tdr[0]);
        chk("a_ctrl", {load_a, dw_a, en_a, cks_a}, {m_tcr[0][7], m_tcr[0][5], m_tcr[0][4], m_tcr[0][1:0]});
        chk("b_tdr_o", tdr_b, m_tdr[1]);
        chk("b_ctrl", {load_b, dw_b, en_b, cks_b}, {m_tcr[1][7], m_tcr[1][5], m_tcr[1][4], m_tcr[1][1:0]});
    endtask

    // abort_at != 0 drops psel in that ACCESS cycle (only instance B is still waiting then).
    task automatic xfer(input bit wr, input bit [7:0] a, input bit [7:0] d,
                        input bit hw_set, input int abort_at);
        int cyc, lat_a, lat_b;
        qa.push_back(model_xfer(0, wr, a, d, hw_set));
        if (abort_at == 0) qb.push_back(model_xfer(1, wr, a, d, hw_set));
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1; lat_a = 0; lat_b = 0;
        while (cyc < 16) begin
            if (abort_at != 0) begin
                if (cyc == abort_at) break;
            end else if (lat_a != 0 && lat_b != 0) break;
            ovf_a = hw_set && pready_a && lat_a == 0;
            ovf_b = hw_set && pready_b && lat_b == 0 && abort_at == 0;
            if (pready_a && lat_a == 0) lat_a = cyc;
            if (pready_b && lat_b == 0) lat_b = cyc;
            @(posedge pclk); #1;
            ovf_a = 1'b0; ovf_b = 1'b0;
            cyc++;
        end
        psel = 1'b0; penable = 1'b0;
        if (cyc >= 16) chk("xfer_timeout", cyc, 0);
        chk("a_latency", lat_a, 1 + WS_A);
        if (abort_at == 0) chk("b_latency", lat_b, 1 + WS_B);
        else chk("b_no_pready_on_abort", lat_b, 0);
    endtask

    task automatic hw_pulse(input bit o, input bit u);
        @(posedge pclk); #1;
        ovf_a = o; ovf_b = o; udf_a = u; udf_b = u;
        @(posedge pclk); #1;
        ovf_a = 1'b0; ovf_b = 1'b0; udf_a = 1'b0; udf_b = 1'b0;
        for (int k = 0; k < 2; k++) m_tsr[k] = m_tsr[k] | {u, o};
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_out"}, {prdata_a, pready_a, pslverr_a, tdr_a, load_a, dw_a, en_a, cks_a}, 0);
        chk({tag, "_b_out"}, {prdata_b, pready_b, pslverr_b, tdr_b, load_b, dw_b, en_b, cks_b}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge pclk);
        #1 chk_reset_outputs("reset");
        preset = 1'b0;

        for (int a = 0; a < 3; a++) xfer(1'b0, 8'(a), 8'h00, 1'b0, 0);
        chk_ctrl();

        xfer(1'b1, 8'h00, 8'hA5, 1'b0, 0);
        xfer(1'b1, 8'h01, 8'hFF, 1'b0, 0);
        xfer(1'b0, 8'h01, 8'h00, 1'b0, 0);
        chk_ctrl();

        hw_pulse(1'b0, 1'b1);
        xfer(1'b0, 8'h02, 8'h00, 1'b0, 0);
        xfer(1'b1, 8'h02, 8'hFD, 1'b0, 0);
        xfer(1'b0, 8'h02, 8'h00, 1'b0, 0);
        hw_pulse(1'b1, 1'b0);
        xfer(1'b1, 8'h02, 8'h00, 1'b1, 0);
        xfer(1'b0, 8'h02, 8'h00, 1'b0, 0);
        xfer(1'b0, 8'h02, 8'h00, 1'b1, 0);
        xfer(1'b0, 8'h02, 8'h00, 1'b0, 0);

        xfer(1'b1, 8'h00, 8'h3C, 1'b0, 2);
        repeat (6) @(posedge pclk);
        #1 xfer(1'b0, 8'h00, 8'h00, 1'b0, 0);
        chk_ctrl();

        xfer(1'b1, 8'h05, 8'h77, 1'b0, 0);
        chk_ctrl();
        xfer(1'b0, 8'h05, 8'h00, 1'b0, 0);
        xfer(1'b1, 8'h03, 8'h77, 1'b0, 0);
        xfer(1'b0, 8'h03, 8'h00, 1'b0, 0);
        for (int a = 0; a < 3; a++) xfer(1'b0, 8'(a), 8'h00, 1'b0, 0);

        for (int i = 0; i < 120; i++) begin
            xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)), 8'($urandom),
                 ($urandom_range(0, 4) == 0), 0);
            if ($urandom_range(0, 3) == 0)
                hw_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk_ctrl();
        end

        xfer(1'b1, 8'h00, 8'h10, 1'b0, 0);
        xfer(1'b1, 8'h01, 8'h31, 1'b0, 0);
        chk_ctrl();
        qa.push_back(model_xfer(0, 1'b1, 8'h00, 8'hFF, 1'b0));
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1 chk_reset_outputs("midreset");
        psel = 1'b0; penable = 1'b0;
        model_reset();
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        chk_ctrl();
        for (int a = 0; a < 3; a++) xfer(1'b0, 8'(a), 8'h00, 1'b0, 0);
        chk_ctrl();

        repeat (3) @(posedge pclk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_apb_regs.md
Name: timer_apb_regs

Overview:
- APB slave register file that sits directly upstream of the 8-bit timer counter core.
- Decodes pclk-domain APB transfers into TDR (0x00), TCR (0x01) and TSR (0x02).
- Drives the counter control outputs: reload value, load, count direction, enable and clock select.
- Captures the counter's overflow/underflow pulses into sticky status bits that software reads and clears.

Parameters:
- WAIT_STATES, 0, number of ACCESS cycles with pready=0 before pready=1 (0..7).
- ADDR_W, 8, paddr width.

Ports:
- pclk  input  1  APB/system clock; every register uses its rising edge.
- preset  input  1  asynchronous, active-high reset.
- psel  input  1  APB select.
- penable  input  1  APB enable (ACCESS phase).
- pwrite  input  1  1=write, 0=read.
- paddr  input  ADDR_W  register address.
- pwdata  input  8  write data.
- prdata  output  8  read data, valid when pready=1.
- pready  output  1  transfer completion.
- pslverr  output  1  error on the completion cycle.
- ovf_set  input  1  one-pclk pulse from the counter on 8'hFF->8'h00 wrap (count up).
- udf_set  input  1  one-pclk pulse from the counter on 8'h00->8'hFF wrap (count down).
- tdr_o  output  8  TDR contents.
- load_o  output  1  TCR[7].
- dw_o  output  1  TCR[5] (1 = count down).
- en_o  output  1  TCR[4].
- cks_o  output  2  TCR[1:0] (00=2T, 01=4T, 10=8T, 11=16T pclk).

Behaviour:
- Reset (preset=1, asynchronous):
  - TDR=0x00, TCR=0x00, TSR=0x00.
  - prdata=0x00, pready=0, pslverr=0; FSM=IDLE; wait counter=0.
  - Hence all control outputs are 0.
- FSM states:
  - IDLE: psel=1 & penable=0 -> SETUP.
  - SETUP: psel=1 & penable=1 -> ACCESS and load the wait counter with WAIT_STATES; psel=0 -> IDLE.
  - ACCESS: while the wait counter is nonzero, hold pready=0 and decrement. When it is zero, pready=1 for exactly one cycle, then go to IDLE, or to SETUP if psel=1 & penable=0 on the following cycle (back-to-back).
  - psel=0 at any point in ACCESS -> IDLE; no commit, pready stays 0.
  - penable=1 seen in IDLE (no SETUP) -> ignored.
- Latency: with WAIT_STATES=0, pready=1 on the first ACCESS cycle (2-cycle transfer); in general 2+WAIT_STATES cycles.
- Writes commit on the pclk edge ending the pready=1 cycle:
  - TDR: all 8 bits writable.
  - TCR: only mask 8'b1011_0011 writable; bits 6,3,2 are stored as 0 and read 0.
- Reads: prdata is registered and updated on the cycle pready goes 1; it holds its value otherwise.
  - TSR reads {6'b0, udf, ovf}.
- Invalid address (paddr > 0x02):
  - pslverr=1 together with pready=1.
  - Writes are dropped; reads return 0x00.
  - pslverr=0 on every other cycle.
- TSR[0] (ovf):
  - Set by ovf_set.
  - Cleared by a committed TSR write with pwdata[0]=0; writing 1 leaves it unchanged.
- TSR[1] (udf): same rule as TSR[0], using udf_set and pwdata[1].
- Simultaneous events:
  - Hardware set and software clear of the same bit in one cycle -> bit ends at 1 (set wins).
  - Set while a read of TSR is completing -> prdata shows the pre-edge value and the bit is 1 afterwards.
- load_o is a plain level. Software clears TCR[7] with a later write; the block never auto-clears it.
- Reset mid-transfer: FSM returns to IDLE immediately and the transfer is abandoned. The master retries after reset deasserts.
- cks_o and dw_o change only on committed TCR writes, never spontaneously.

Optional Feature:
- Macro: TIMER_APB_IRQ_EN.
- Defined:
  - Adds TIER at 0x03, bits[1:0] read/write; bits 7:2 read 0; reset 0x00.
  - Adds output port irq (1 bit), registered: irq = |(TSR[1:0] & TIER[1:0]), one-cycle delay after TSR/TIER change, reset 0.
  - Invalid address threshold becomes paddr > 0x03.
- Undefined: no TIER and no irq port; 0x03 returns pslverr=1.

Test Plan:
- Reset, then read 0x00, 0x01, 0x02 -> each prdata=0x00, pslverr=0. Also check load_o/dw_o/en_o/cks_o all 0.
- Write TDR=0xA5; write TCR=0xFF -> TCR reads 0xB3; tdr_o=0xA5, load_o=1, dw_o=1, en_o=1, cks_o=2'b11.
- Pulse udf_set one cycle -> TSR reads 0x02. Write TSR=0xFD -> TSR reads 0x00. Pulse ovf_set on the same cycle a TSR=0x00 write commits -> TSR reads 0x01.
- WAIT_STATES=3: read TDR -> pready low for 3 ACCESS cycles, high on the 4th; drop psel in the 2nd ACCESS cycle of a write -> register unchanged.
- Write paddr=0x05, pwdata=0x77 -> pslverr=1 with pready=1, no register changes; read 0x05 -> 0x00, pslverr=1.
- Program TDR=0x10, TCR=0x31, then assert preset mid-transfer -> outputs 0 asynchronously and all registers read 0x00.
